// File: rtl/rr_mux4.sv
// Four-to-one round-robin merging mux: four valid/ready sources onto one
// registered output stream tagged with the source channel in out_sel.
module rr_mux4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             load;
    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic [3:0]       grant;
    logic [WIDTH-1:0] grant_data;

    // The output register is free when empty or when its beat leaves this cycle.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_any = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        // Scanning from the far end lets the channel nearest ptr win by overwriting.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant    = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    assign in_ready = (load && !rst) ? grant : 4'b0000;

    always_comb begin
        grant_data = in_a;
        case (grant_idx)
            2'd0:    grant_data = in_a;
            2'd1:    grant_data = in_b;
            2'd2:    grant_data = in_c;
            default: grant_data = in_d;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        beat_cnt_d  = beat_cnt_q;
        if (load) begin
            if (grant_any) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_sel_d   = grant_idx;
                ptr_d       = grant_idx + 2'd1;
                beat_cnt_d  = beat_cnt_q + CNT_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            beat_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_rr_mux4.sv
// Bench for rr_mux4: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model.
module tb_rr_mux4;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] din [4];
    logic [WIDTH-1:0] in_a, in_b, in_c, in_d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic [CNT_W-1:0] beat_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    logic [3:0] rdy_s;

    // Model state: what the output register and arbiter must hold.
    int               m_ptr;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    int               m_os;
    int               m_cnt;
    int               m_g;
    bit               m_ld;

    assign in_a = din[0];
    assign in_b = din[1];
    assign in_c = din[2];
    assign in_d = din[3];

    rr_mux4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid channel in round-robin order starting at p, or -1.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        if (rst) return 4'b0000;
        if (m_ov && !out_ready) return 4'b0000;
        g = pick(in_valid, m_ptr);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    always @(posedge clk) begin
        m_ld = !m_ov || out_ready;
        m_g  = pick(in_valid, m_ptr);
        if (rst) begin
            m_ov = 1'b0; m_od = '0; m_os = 0; m_cnt = 0; m_ptr = 0;
        end else if (m_ld) begin
            if (m_g >= 0) begin
                m_ov  = 1'b1;
                m_od  = din[m_g];
                m_os  = m_g;
                m_ptr = (m_g + 1) % 4;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else begin
                m_ov = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        rdy_s = in_ready;
        if (chk_en) begin
            check("model_in_ready", 32'(in_ready), 32'(exp_ready()));
            check("model_out_valid", 32'(out_valid), 32'(m_ov));
            check("model_out_data", 32'(out_data), 32'(m_od));
            check("model_out_sel", 32'(out_sel), 32'(m_os));
            check("model_beat_cnt", 32'(beat_cnt), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [3:0] v);
        in_valid = v;
        din[0] = 4'd1; din[1] = 4'd2; din[2] = 4'd3; din[3] = 4'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_beat_cnt", 32'(beat_cnt), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);
        in_valid = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = '0;

        // Single beat on channel c, then idle drain.
        do_reset();
        in_valid = 4'b0100; din[2] = 4'hA;
        @(negedge clk);
        check("t1_in_ready", 32'(in_ready), 32'h4);
        step();
        in_valid = 4'b0000;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_out_data", 32'(out_data), 32'hA);
        check("t1_out_sel", 32'(out_sel), 32'h2);
        check("t1_beat_cnt", 32'(beat_cnt), 32'h1);
        step();
        @(negedge clk);
        check("t5_drain_valid", 32'(out_valid), 32'h0);
        check("t5_hold_data", 32'(out_data), 32'hA);
        check("t5_hold_sel", 32'(out_sel), 32'h2);

        // All four valid: a,b,c,d,a,b,c,d.
        do_reset();
        set_all(4'b1111);
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            check("t2_out_data", 32'(out_data), 32'(i % 4 + 1));
            check("t2_out_sel", 32'(out_sel), 32'(i % 4));
        end
        check("t2_beat_cnt", 32'(beat_cnt), 32'd8);

        // Backpressure holds beat 5, then loads b with no bubble.
        do_reset();
        in_valid = 4'b0001; din[0] = 4'd5;
        step();
        out_ready = 1'b0;
        in_valid = 4'b1111; din[0] = 4'd6; din[1] = 4'd7; din[2] = 4'd8; din[3] = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_in_ready_held", 32'(in_ready), 32'h0);
            check("t3_data_held", 32'(out_data), 32'd5);
            check("t3_cnt_held", 32'(beat_cnt), 32'd1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", 32'(in_ready), 32'h2);
        step();
        @(negedge clk);
        check("t3_no_bubble", 32'(out_valid), 32'h1);
        check("t3_next_data", 32'(out_data), 32'd7);
        check("t3_next_cnt", 32'(beat_cnt), 32'd2);

        // Fairness: d waiting behind a is served right after the current a beat.
        do_reset();
        in_valid = 4'b0001; din[0] = 4'd1;
        step();
        in_valid = 4'b1001; din[3] = 4'd4;
        @(negedge clk);
        check("t4_d_granted", 32'(in_ready), 32'h8);
        step();
        in_valid = 4'b0001;
        @(negedge clk);
        check("t4_d_out_sel", 32'(out_sel), 32'h3);
        check("t4_a_next", 32'(in_ready), 32'h1);

        // Reset mid-stream with ptr=2, beat_cnt=9.
        do_reset();
        set_all(4'b1111);
        repeat (5) step();
        in_valid = 4'b0010;
        repeat (4) step();
        @(negedge clk);
        check("t6_pre_cnt", 32'(beat_cnt), 32'd9);
        check("t6_pre_valid", 32'(out_valid), 32'h1);
        rst = 1'b1; in_valid = 4'b1111;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_valid", 32'(out_valid), 32'h0);
        check("t6_post_cnt", 32'(beat_cnt), 32'h0);
        check("t6_post_ready", 32'(in_ready), 32'h1);
        step();
        @(negedge clk);
        check("t6_first_sel", 32'(out_sel), 32'h0);

        // Counter wrap after 256 accepted beats.
        do_reset();
        set_all(4'b1111);
        repeat (255) step();
        @(negedge clk);
        check("wrap_255", 32'(beat_cnt), 32'd255);
        step();
        @(negedge clk);
        check("wrap_0", 32'(beat_cnt), 32'd0);
        check("wrap_valid", 32'(out_valid), 32'h1);

        // Random traffic obeying the source protocol.
        do_reset();
        in_valid = 4'b0000;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (!in_valid[k] || rdy_s[k]) begin
                    in_valid[k] = ($urandom_range(0, 2) != 0);
                    din[k] = 4'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 249) == 0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux4.md
Name: rr_mux4

Overview:
- Four-to-one merging multiplexer; the inverse of the team's 1-to-4 demux.
- Four independent source channels, each a WIDTH-bit data stream with valid/ready handshake, are arbitrated round-robin onto one registered output stream.
- Each output beat carries a 2-bit channel tag (out_sel) in the same encoding the demux uses for sel: 00=a, 01=b, 10=c, 11=d.
- Sits upstream of a shared link; a demux at the far end re-splits the stream using out_sel.

Parameters:
WIDTH, 4, data width of every channel and of out_data
CNT_W, 8, width of the accepted-beat counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  4  per-channel valid; bit 0=a, 1=b, 2=c, 3=d
in_ready  output  4  per-channel ready; same bit mapping
in_a  input  WIDTH  channel a data
in_b  input  WIDTH  channel b data
in_c  input  WIDTH  channel c data
in_d  input  WIDTH  channel d data
out_valid  output  1  output beat valid
out_ready  input  1  downstream ready
out_data  output  WIDTH  output beat data
out_sel  output  2  source channel of the current output beat
beat_cnt  output  CNT_W  count of beats accepted from inputs since reset

Behaviour:
- Single clock domain. Reset is synchronous and active-high; rst is sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=00, beat_cnt=0, round-robin pointer ptr=0 (channel a has highest priority). in_ready=4'b0000 in the reset cycle.
- Transfer rule: a beat transfers on a channel when valid and ready are both 1 at a rising edge. Sources must not make valid depend on ready, and must hold valid and data stable until the transfer.
- Load enable: load = !out_valid | out_ready. The output register is free when it is empty, or when its current beat leaves this cycle.
- Arbitration (combinational):
  - Search channels in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - grant = the first channel with in_valid=1; grant is one-hot or zero.
  - in_ready[k] = load & grant[k]. At most one in_ready bit is high per cycle.
- On a clock edge with load=1 and a grant to channel k:
  - out_data <= in_k, out_sel <= k, out_valid <= 1.
  - ptr <= (k+1) mod 4.
  - beat_cnt <= beat_cnt+1, wrapping from 2^CNT_W-1 to 0.
- On a clock edge with load=1 and no valid input: out_valid <= 0. out_data, out_sel and ptr hold.
- On a clock edge with load=0 (out_valid=1 and out_ready=0): out_valid, out_data, out_sel, ptr and beat_cnt all hold; in_ready=0. No beat is dropped or overwritten.
- Latency and throughput:
  - An input accepted at edge N appears at the outputs after edge N, so it is visible in cycle N+1.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Fairness:
  - Pointer advances only on a grant. With all four inputs continuously valid, the grant order is a,b,c,d,a,...
  - A channel waits at most 3 accepted beats from other channels before it is served.
- Simultaneous events: a beat leaving (out_ready=1) and a new beat loading in the same edge is a normal back-to-back transfer; the new beat replaces the old one with no bubble.
- Reset mid-operation: an in-flight output beat is discarded (out_valid=0 next cycle), ptr returns to 0, and beat_cnt clears. Input beats not yet accepted remain the sources' responsibility.
- Size: no storage beyond the output register, ptr (2 bits) and beat_cnt.

Test Plan:
1. Reset, then only in_valid=4'b0100 with in_c=4'hA and out_ready=1 -> in_ready=4'b0100 for one cycle; next cycle out_valid=1, out_data=A, out_sel=10, beat_cnt=1.
2. All four valid with a=1, b=2, c=3, d=4 held, out_ready=1 for 8 cycles -> out_data sequence 1,2,3,4,1,2,3,4; out_sel sequence 00,01,10,11 repeating; beat_cnt=8.
3. Backpressure: out_valid=1 holding data 5 with out_ready=0 for 3 cycles while all inputs are valid -> in_ready=0 throughout; out_data stays 5 and beat_cnt is unchanged; on the cycle out_ready rises, the next beat loads with no bubble.
4. Fairness: channel a valid continuously, channel d becomes valid while a is being served -> d is granted immediately after the current a beat (ptr has advanced past a), so d waits no more than 3 beats.
5. Idle drain: a single beat is accepted, then no inputs are valid and out_ready=1 -> out_valid=1 for exactly one cycle then 0; out_data/out_sel hold their last values.
6. Reset mid-stream (out_valid=1, ptr=2, beat_cnt=9) -> next cycle out_valid=0, beat_cnt=0; with all inputs valid, the first grant after reset goes to channel a. A separate check preloads beat_cnt to 255 (CNT_W=8), accepts one beat, and requires beat_cnt to wrap to 0.
